// File: rtl/systolic_row_pkg.sv
// rtl/systolic_row_pkg.sv - shared widths, derived step count and lane types for the systolic datapath
package systolic_row_pkg;

   localparam int DEF_DIM     = 8;
   localparam int DEF_BITS_AB = 8;
   localparam int DEF_BITS_C  = 16;

   // A full DIMxDIM product needs 3*DIM-2 enabled steps to drain through one row.
   function automatic int steps_for(input int dim);
      return 3 * dim - 2;
   endfunction

   localparam int DEF_STEPS = steps_for(DEF_DIM);

   typedef logic signed [DEF_BITS_AB-1:0] operand_t;
   typedef logic signed [DEF_BITS_C-1:0]  acc_t;

   typedef logic [DEF_DIM-1:0][DEF_BITS_AB-1:0] ab_lanes_t;
   typedef logic [DEF_DIM-1:0][DEF_BITS_C-1:0]  c_lanes_t;

endpackage

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - one processing element: A/B pass-through registers and a wrapping MAC
module systolic_pe
   import systolic_row_pkg::*;
#(
   parameter int BITS_AB = DEF_BITS_AB,
   parameter int BITS_C  = DEF_BITS_C
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic                      wr_en,
   input  logic                      clr,
   input  logic signed [BITS_AB-1:0] a_in,
   input  logic signed [BITS_AB-1:0] b_in,
   input  logic signed [BITS_C-1:0]  c_in,
   output logic signed [BITS_AB-1:0] a_out,
   output logic signed [BITS_AB-1:0] b_out,
   output logic signed [BITS_C-1:0]  c_out
);

   logic signed [BITS_AB-1:0]   a_q, a_d;
   logic signed [BITS_AB-1:0]   b_q, b_d;
   logic signed [BITS_C-1:0]    c_q, c_d;
   logic signed [2*BITS_AB-1:0] prod;

   always_comb begin
      a_d  = a_q;
      b_d  = b_q;
      c_d  = c_q;
      prod = a_in * b_in;
      // clr and WrEn only touch the accumulator; the operand pipeline moves on en alone.
      if (clr) begin
         c_d = '0;
      end else if (wr_en) begin
         c_d = c_in;
      end else if (en) begin
         a_d = a_in;
         b_d = b_in;
         c_d = c_q + BITS_C'(prod);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
         c_q <= '0;
      end else begin
         a_q <= a_d;
         b_q <= b_d;
         c_q <= c_d;
      end
   end

   assign a_out = a_q;
   assign b_out = b_q;
   assign c_out = c_q;

endmodule

// File: rtl/systolic_row.sv
// rtl/systolic_row.sv - row of DIM PEs with A chained left to right and a saturating step counter
module systolic_row
   import systolic_row_pkg::*;
#(
   parameter int DIM     = DEF_DIM,
   parameter int BITS_AB = DEF_BITS_AB,
   parameter int BITS_C  = DEF_BITS_C,
   parameter int STEPS   = steps_for(DIM)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    WrEn,
   input  logic                    clr,
   input  logic [BITS_AB-1:0]      Ain,
   input  logic [DIM*BITS_AB-1:0]  Bin,
   input  logic [DIM*BITS_C-1:0]   Cin,
   output logic [BITS_AB-1:0]      Aout,
   output logic [DIM*BITS_AB-1:0]  Bout,
   output logic [DIM*BITS_C-1:0]   Cout,
   output logic                    done
);

   localparam int CNT_W = $clog2(STEPS + 1);

   logic [DIM:0][BITS_AB-1:0] a_chain;
   logic [CNT_W-1:0]          cnt_q, cnt_d;

   assign a_chain[0] = Ain;

   for (genvar i = 0; i < DIM; i++) begin : g_pe
      systolic_pe #(
         .BITS_AB(BITS_AB),
         .BITS_C (BITS_C)
      ) u_pe (
         .clk  (clk),
         .rst_n(rst_n),
         .en   (en),
         .wr_en(WrEn),
         .clr  (clr),
         .a_in (a_chain[i]),
         .b_in (Bin[i*BITS_AB +: BITS_AB]),
         .c_in (Cin[i*BITS_C +: BITS_C]),
         .a_out(a_chain[i+1]),
         .b_out(Bout[i*BITS_AB +: BITS_AB]),
         .c_out(Cout[i*BITS_C +: BITS_C])
      );
   end

   assign Aout = a_chain[DIM];

   // A WrEn cycle is not a compute step, so it must not advance the count.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (!WrEn && en && (cnt_q != CNT_W'(STEPS))) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == CNT_W'(STEPS));

endmodule

// File: tb/tb_systolic_row.sv
// tb/tb_systolic_row.sv - directed self-checking bench for systolic_row
module tb_systolic_row;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         en = 1'b0;
   logic         WrEn = 1'b0;
   logic         clr = 1'b0;
   logic [7:0]   Ain = '0;
   logic [63:0]  Bin = '0;
   logic [127:0] Cin = '0;
   logic [7:0]   Aout;
   logic [63:0]  Bout;
   logic [127:0] Cout;
   logic         done;

   int pass_cnt = 0;
   int total_cnt = 0;

   systolic_row dut (
      .clk (clk),
      .rst_n(rst_n),
      .en  (en),
      .WrEn(WrEn),
      .clr (clr),
      .Ain (Ain),
      .Bin (Bin),
      .Cin (Cin),
      .Aout(Aout),
      .Bout(Bout),
      .Cout(Cout),
      .done(done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      total_cnt++;
      if (Cout !== 128'd0) $display("FAIL reset_cout got=%h want=0", Cout); else pass_cnt++;
      total_cnt++;
      if (Bout !== 64'd0) $display("FAIL reset_bout got=%h want=0", Bout); else pass_cnt++;
      total_cnt++;
      if (Aout !== 8'd0) $display("FAIL reset_aout got=%h want=0", Aout); else pass_cnt++;
      total_cnt++;
      if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single_mac();
      Ain = 8'd3;
      Bin = {8{8'd4}};
      en = 1'b1;
      step();
      en = 1'b0;
      total_cnt++;
      if (Cout !== {112'd0, 16'd12}) $display("FAIL mac_first got=%h want=%h", Cout, {112'd0, 16'd12}); else pass_cnt++;
      total_cnt++;
      if (Bout !== {8{8'd4}}) $display("FAIL mac_bout got=%h want=%h", Bout, {8{8'd4}}); else pass_cnt++;
      Ain = 8'd0;
      en = 1'b1;
      step();
      en = 1'b0;
      total_cnt++;
      if (Cout !== {96'd0, 16'd12, 16'd12}) $display("FAIL mac_second got=%h want=%h", Cout, {96'd0, 16'd12, 16'd12}); else pass_cnt++;
   endtask

   task automatic test_signed_wrap();
      do_clr();
      Cin = {112'd0, 16'h7FF0};
      WrEn = 1'b1;
      step();
      WrEn = 1'b0;
      total_cnt++;
      if (Cout[15:0] !== 16'h7FF0) $display("FAIL preload got=%h want=7ff0", Cout[15:0]); else pass_cnt++;
      Ain = 8'd127;
      Bin = {56'd0, 8'd127};
      en = 1'b1;
      step();
      en = 1'b0;
      total_cnt++;
      if (Cout !== {112'd0, 16'hBEF1}) $display("FAIL wrap got=%h want=%h", Cout, {112'd0, 16'hBEF1}); else pass_cnt++;
      do_clr();
      Ain = 8'hFE;
      Bin = {56'd0, 8'd5};
      en = 1'b1;
      step();
      en = 1'b0;
      total_cnt++;
      if (Cout[15:0] !== 16'hFFF6) $display("FAIL signed_neg got=%h want=fff6", Cout[15:0]); else pass_cnt++;
   endtask

   task automatic test_propagation();
      logic [127:0] exp_c;
      do_clr();
      Ain = 8'd0;
      Bin = '0;
      en = 1'b1;
      repeat (8) step();
      en = 1'b0;
      do_clr();
      Bin = {8{8'd1}};
      en = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         Ain = 8'(k);
         step();
      end
      en = 1'b0;
      Ain = 8'd0;
      for (int i = 0; i < 8; i++) exp_c[i*16 +: 16] = 16'((8 - i) * (9 - i) / 2);
      total_cnt++;
      if (Aout !== 8'd1) $display("FAIL prop_first got=%0d want=1", Aout); else pass_cnt++;
      total_cnt++;
      if (Cout !== exp_c) $display("FAIL prop_cout got=%h want=%h", Cout, exp_c); else pass_cnt++;
      repeat (3) step();
      total_cnt++;
      if (Aout !== 8'd1) $display("FAIL hold_aout got=%0d want=1", Aout); else pass_cnt++;
      total_cnt++;
      if (Cout !== exp_c) $display("FAIL hold_cout got=%h want=%h", Cout, exp_c); else pass_cnt++;
      total_cnt++;
      if (Bout !== {8{8'd1}}) $display("FAIL hold_bout got=%h want=%h", Bout, {8{8'd1}}); else pass_cnt++;
      en = 1'b1;
      for (int k = 2; k <= 8; k++) begin
         step();
         total_cnt++;
         if (Aout !== 8'(k)) $display("FAIL prop_order got=%0d want=%0d", Aout, k); else pass_cnt++;
      end
      en = 1'b0;
   endtask

   task automatic test_priority();
      Cin = {8{16'd9}};
      Ain = 8'd7;
      Bin = {8{8'd2}};
      clr = 1'b1;
      WrEn = 1'b1;
      en = 1'b1;
      step();
      clr = 1'b0;
      WrEn = 1'b0;
      en = 1'b0;
      total_cnt++;
      if (Cout !== 128'd0) $display("FAIL prio_clr_cout got=%h want=0", Cout); else pass_cnt++;
      total_cnt++;
      if (Aout !== 8'd8) $display("FAIL prio_clr_aout got=%0d want=8", Aout); else pass_cnt++;
      total_cnt++;
      if (done !== 1'b0) $display("FAIL prio_clr_done got=%b want=0", done); else pass_cnt++;
      Cin = {8{16'd5}};
      WrEn = 1'b1;
      en = 1'b1;
      step();
      WrEn = 1'b0;
      en = 1'b0;
      total_cnt++;
      if (Cout !== {8{16'd5}}) $display("FAIL prio_wren_cout got=%h want=%h", Cout, {8{16'd5}}); else pass_cnt++;
      total_cnt++;
      if (Aout !== 8'd8) $display("FAIL prio_wren_aout got=%0d want=8", Aout); else pass_cnt++;
      total_cnt++;
      if (Bout !== {8{8'd1}}) $display("FAIL prio_wren_bout got=%h want=%h", Bout, {8{8'd1}}); else pass_cnt++;
   endtask

   task automatic test_done();
      do_clr();
      Ain = 8'd0;
      Bin = '0;
      en = 1'b1;
      repeat (21) step();
      total_cnt++;
      if (done !== 1'b0) $display("FAIL done_early got=%b want=0", done); else pass_cnt++;
      step();
      total_cnt++;
      if (done !== 1'b1) $display("FAIL done_rise got=%b want=1", done); else pass_cnt++;
      Ain = 8'd1;
      Bin = {8{8'd1}};
      repeat (3) step();
      en = 1'b0;
      total_cnt++;
      if (done !== 1'b1) $display("FAIL done_sticky got=%b want=1", done); else pass_cnt++;
      total_cnt++;
      if (Cout[15:0] !== 16'd3) $display("FAIL done_accum got=%0d want=3", Cout[15:0]); else pass_cnt++;
      do_clr();
      total_cnt++;
      if (done !== 1'b0) $display("FAIL done_clr got=%b want=0", done); else pass_cnt++;
   endtask

   task automatic test_reset_midrun();
      Cin = {112'd0, 16'h0123};
      WrEn = 1'b1;
      step();
      WrEn = 1'b0;
      Ain = 8'd9;
      Bin = {8{8'd1}};
      total_cnt++;
      if (Cout[15:0] !== 16'h0123) $display("FAIL mid_preload got=%h want=0123", Cout[15:0]); else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if (Cout !== 128'd0) $display("FAIL mid_reset_cout got=%h want=0", Cout); else pass_cnt++;
      total_cnt++;
      if (Bout !== 64'd0) $display("FAIL mid_reset_bout got=%h want=0", Bout); else pass_cnt++;
      total_cnt++;
      if (Aout !== 8'd0) $display("FAIL mid_reset_aout got=%h want=0", Aout); else pass_cnt++;
      total_cnt++;
      if (done !== 1'b0) $display("FAIL mid_reset_done got=%b want=0", done); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single_mac();
      test_signed_wrap();
      test_propagation();
      test_priority();
      test_done();
      test_reset_midrun();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/systolic_row.md
Name: systolic_row

Overview:
- One horizontal row of DIM multiply-accumulate processing elements (PEs) in the systolic matrix-multiply datapath.
- Sits directly downstream of the staggered delay FIFOs:
  - the row's A lane is one FIFO output byte, entering from the left;
  - the B operands enter from the top (the previous row or the B FIFOs);
  - each PE passes its A right, passes its B down, and accumulates A*B into a local C register.
- Supports C preload/readback and counts compute steps to flag row completion.

Parameters:
DIM, 8, number of PEs in the row (columns)
BITS_AB, 8, signed operand width of A and B
BITS_C, 16, signed accumulator width
STEPS, 3*DIM-2, enabled compute cycles needed for a full DIMxDIM product to drain through the row

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  advance one systolic step (shift A/B, accumulate)
WrEn  input  1  load all C accumulators from Cin
clr  input  1  synchronous clear of C accumulators and step counter
Ain  input  BITS_AB  signed A operand entering PE 0 (from FIFO)
Bin  input  DIM*BITS_AB  signed B operands, lane i to PE i
Cin  input  DIM*BITS_C  preload values, lane i to PE i
Aout  output  BITS_AB  A leaving PE DIM-1 (registered)
Bout  output  DIM*BITS_AB  registered B from each PE, to the row below
Cout  output  DIM*BITS_C  current accumulator of each PE
done  output  1  high when the step count has reached STEPS

Behaviour:
- Reset (rst_n low, asynchronous):
  - every PE A register, B register and C accumulator is 0;
  - step counter is 0;
  - Aout, Bout, Cout and done are all 0;
  - a reset mid-computation discards all partial sums.
- Priority each rising edge: clr > WrEn > en > hold.
- clr:
  - all C accumulators become 0 and the step counter becomes 0;
  - A/B registers are unchanged.
- WrEn:
  - C[i] <= Cin lane i for every PE;
  - A/B registers and the counter are unchanged;
  - en is ignored that cycle.
- en (without clr/WrEn), per PE i:
  - Areg[i] <= (i==0 ? Ain : Areg[i-1]);
  - Breg[i] <= Bin lane i;
  - C[i] <= C[i] + sext(Ain_i * Bin_i), where Ain_i is the A value presented to PE i this cycle (Ain for i==0, else Areg[i-1]).
- Hold: with en, WrEn and clr all low, every register holds its value.
- Latency and outputs:
  - Aout = Areg[DIM-1], i.e. A reaches Aout DIM cycles after entering Ain;
  - Bout lane i = Breg[i], one cycle of latency;
  - Cout is combinational from the C registers, so a write is visible the cycle after the edge.
- Arithmetic:
  - product is signed 2*BITS_AB wide, sign-extended to BITS_C;
  - the sum wraps modulo 2^BITS_C, with no saturation and no overflow flag.
- Step counter:
  - increments on each en cycle, saturating at STEPS;
  - done = (count == STEPS);
  - done stays high until clr or reset, and further en still accumulates.
- Simultaneous events:
  - clr together with en clears C;
  - WrEn together with en loads Cin and does not shift.
- Lane packing: lane i occupies bits [(i+1)*W-1 : i*W] of its bus.

Decomposition:
- Shared package holds:
  - DIM, BITS_AB and BITS_C defaults;
  - the derived STEPS constant;
  - typedefs for the signed operand and accumulator;
  - the packed lane array types used by the FIFO, row and array top.
- Natural sub-module `systolic_pe`: a single PE with A/B pass-through registers, MAC and load/clear, generate-instantiated DIM times.
- The step counter and done logic live in `systolic_row`.

Test Plan:
- Reset: assert rst_n=0 mid-run after C[0]=0x0123 -> Cout, Bout, Aout and done are 0 immediately, without waiting for a clock edge.
- Single MAC: Ain=3, all Bin lanes=4, one en -> C[0]=12, other C unchanged, Bout lanes=4.
  - Next en with Ain=0 -> C[1]=12.
- Signed/wrap:
  - C[0] preloaded 0x7FF0 via WrEn, then Ain=127, Bin0=127, en -> C[0]=0x7FF0+16129 mod 2^16=0xBEF1;
  - Ain=-2, Bin0=5 from C=0 -> C[0]=0xFFF6.
- Propagation: Ain=1..8 on 8 consecutive en cycles, B lanes=1 -> Aout shows 1 on the cycle after the 8th edge, and order is preserved.
  - With en low for 3 cycles in between, all values hold.
- Priority: clr+WrEn+en in the same cycle -> C all 0, counter 0.
  - WrEn+en with Cin lanes=5 -> C=5 and A regs unshifted.
- Done: 22 en cycles (DIM=8) -> done rises after the 22nd edge and stays high through 3 more en.
  - clr -> done=0.
